keypad_digit_buffer: RTL and testbench
======================================

# keypad_digit_buffer

Parametrised digit-entry buffer for keypad input. It accumulates WIDTH-bit digit codes into a COUNT-digit shift register with selectable shift direction, digit counting, full/empty flags, a configurable overflow policy and optional backspace. On an enter command it commits the buffered value to a downstream consumer through a valid/ready handshake. It sits between the keypad decoder and the code-compare/display logic.

## Interface
- COUNT, 4, number of digit slots (≥2)
- WIDTH, 4, bits per digit
- OVERFLOW_MODE, 0, 0 = drop new digit when full; 1 = accept it and discard the oldest digit
- trig  in  1  clock; all state changes on posedge
- reset  in  1  asynchronous, active-high; clears all state
- dir  in  1  0 = Left (new digit enters at LSB slot), 1 = Right (new digit enters at MSB slot); sampled on every shift
- in_valid  in  1  one-cycle digit strobe
- in  in  WIDTH  digit code, qualified by in_valid
- clr  in  1  one-cycle clear command
- bksp  in  1  one-cycle backspace command
- enter  in  1  one-cycle commit command
- out  out  COUNT*WIDTH  live buffer contents
- count  out  $clog2(COUNT+1)  digits currently held
- empty  out  1  count == 0
- full  out  1  count == COUNT
- overflow  out  1  one-cycle pulse when a digit arrives while full
- out_valid  out  1  committed value available
- out_ready  in  1  consumer accepts committed value
- out_data  out  COUNT*WIDTH  committed value, stable while out_valid
- out_count  out  $clog2(COUNT+1)  digit count of committed value

## Operation
- FSM states: EMPTY, ENTRY, FULL, HOLD. Reset state EMPTY; all outputs 0 except empty = 1.
- Command priority per cycle: clr > enter > bksp > in_valid; only the highest-priority asserted event acts.
- Digit shift, Left: out <= {out[COUNT*WIDTH-WIDTH-1:0], in}. Right: out <= {in, out[COUNT*WIDTH-1:WIDTH]}. count +1.
- EMPTY/ENTRY + digit: shift; go ENTRY, or FULL when count reaches COUNT.
- FULL + digit: overflow pulses. OVERFLOW_MODE 0: buffer unchanged. OVERFLOW_MODE 1: shift as normal (oldest digit falls off), count stays COUNT.
- Backspace removes the most recent digit: Left out <= out >> WIDTH; Right out <= out << WIDTH; zero fill; count −1; FULL→ENTRY, count 1→EMPTY. Ignored in EMPTY.
- clr in any state: out, count, out_data, out_count cleared, out_valid dropped, go EMPTY.
- enter in ENTRY/FULL: out_data <= out, out_count <= count, out_valid <= 1, go HOLD. Ignored in EMPTY and HOLD.
- HOLD: in_valid and bksp ignored (no overflow pulse). When out_valid && out_ready: out_valid <= 0, out and count cleared, go EMPTY.
- dir change mid-entry is legal; it affects subsequent shifts only, existing contents are not reordered.

## Timing
- All outputs registered; every event takes effect one cycle after the sampling edge.
- Digit at edge N: out/count/full/empty updated after edge N; overflow high for the cycle after edge N.
- enter at edge N: out_valid high after edge N; out_data stable until handshake or clr.
- Handshake at edge M: out_valid low after M; a digit at edge M is dropped; first digit accepted at edge M+1.
- out_ready while out_valid low has no effect; out_ready may be held high permanently (1-cycle HOLD).
- reset asserted mid-operation forces reset values immediately, independent of trig.

## Configuration
- KEYPAD_BACKSPACE_EN defined: bksp behaves as above.
- Undefined: bksp port is kept but ignored; no backspace logic is synthesised; enter/clr/digit behaviour unchanged.

## Structure
- Package keypad_pkg: FSM state enum (EMPTY, ENTRY, FULL, HOLD), DIR_LEFT/DIR_RIGHT constants, OVF_DROP/OVF_SHIFT constants.
- One sub-module: digit_shifter (combinational next-value for shift-in and backspace given dir), instantiated once.

## Test plan
- COUNT 4, Left: digits 1,2,3,4 -> out 16'h1234, full 1, count 4; enter -> out_valid, out_data 16'h1234, out_count 4.
- Right: digits 1,2 -> out 16'h2100, count 2; bksp -> out 16'h1000, count 1; bksp -> empty 1, EMPTY.
- Full, digit 5: OVERFLOW_MODE 0 -> out 16'h1234, overflow 1 cycle; OVERFLOW_MODE 1 -> out 16'h2345, count 4.
- HOLD with out_ready low for 5 cycles, digits 7,8 sent -> out_data stays 16'h1234; out_ready high -> out_valid low next cycle, count 0.
- Same cycle clr + enter + in_valid -> buffer cleared, out_valid stays 0; enter while EMPTY -> no out_valid.
- reset pulse mid-entry (count 3) -> all outputs reset values asynchronously; KEYPAD_BACKSPACE_EN undefined: bksp -> no change.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad digit buffer.
package keypad_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StEntry,
    StFull,
    StHold
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int unsigned OVF_DROP  = 0;
  localparam int unsigned OVF_SHIFT = 1;

endpackage

// File: rtl/keypad_digit_buffer_if.sv
// Keypad-side command inputs and consumer-side commit handshake of the digit buffer.
interface keypad_digit_buffer_if #(
  parameter int unsigned COUNT = 4,
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned CW = $clog2(COUNT + 1);

  logic                     dir;
  logic                     in_valid;
  logic [WIDTH-1:0]         in;
  logic                     clr;
  logic                     bksp;
  logic                     enter;
  logic [COUNT*WIDTH-1:0]   out;
  logic [CW-1:0]            count;
  logic                     empty;
  logic                     full;
  logic                     overflow;
  logic                     out_valid;
  logic                     out_ready;
  logic [COUNT*WIDTH-1:0]   out_data;
  logic [CW-1:0]            out_count;

  modport master (
    output dir, in_valid, in, clr, bksp, enter, out_ready,
    input  out, count, empty, full, overflow, out_valid, out_data, out_count
  );

  modport slave (
    input  dir, in_valid, in, clr, bksp, enter, out_ready,
    output out, count, empty, full, overflow, out_valid, out_data, out_count
  );

endinterface

// File: rtl/digit_shifter.sv
// Combinational next buffer value for a digit shift-in and (with KEYPAD_BACKSPACE_EN) a
// backspace, in the direction selected by dir.
module digit_shifter
  import keypad_pkg::*;
#(
  parameter int unsigned COUNT = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                   dir,
  input  logic [COUNT*WIDTH-1:0] cur,
  input  logic [WIDTH-1:0]       digit,
`ifdef KEYPAD_BACKSPACE_EN
  output logic [COUNT*WIDTH-1:0] trimmed,
`endif
  output logic [COUNT*WIDTH-1:0] shifted
);

  always_comb begin
    if (dir == DIR_LEFT) begin
      shifted = {cur[COUNT*WIDTH-WIDTH-1:0], digit};
    end else begin
      shifted = {digit, cur[COUNT*WIDTH-1:WIDTH]};
    end
  end

`ifdef KEYPAD_BACKSPACE_EN
  // The most recent digit sits at the entry end, so removal shifts back toward it.
  always_comb begin
    if (dir == DIR_LEFT) begin
      trimmed = cur >> WIDTH;
    end else begin
      trimmed = cur << WIDTH;
    end
  end
`endif

endmodule

// File: rtl/keypad_digit_buffer.sv
// Keypad digit-entry buffer with overflow policy and valid/ready commit of the entered value.
// Backspace support is compiled in only when KEYPAD_BACKSPACE_EN is defined.
module keypad_digit_buffer
  import keypad_pkg::*;
#(
  parameter int unsigned COUNT         = 4,
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned OVERFLOW_MODE = OVF_DROP
) (
  input  logic                  trig,
  input  logic                  reset,
  keypad_digit_buffer_if.slave  bus
);

  localparam int unsigned DW = COUNT * WIDTH;
  localparam int unsigned CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(COUNT);

  state_e          state_q, state_d;
  logic [DW-1:0]   buf_q, buf_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [CW-1:0]   out_count_q, out_count_d;
  logic [DW-1:0]   shifted;
  logic            active;

`ifdef KEYPAD_BACKSPACE_EN
  logic [DW-1:0]   trimmed;
`else
  logic            unused_bksp;
  assign unused_bksp = bus.bksp;
`endif

  digit_shifter #(
    .COUNT (COUNT),
    .WIDTH (WIDTH)
  ) u_shifter (
    .dir     (bus.dir),
    .cur     (buf_q),
    .digit   (bus.in),
`ifdef KEYPAD_BACKSPACE_EN
    .trimmed (trimmed),
`endif
    .shifted (shifted)
  );

  assign active = (state_q == StEntry) || (state_q == StFull);

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;

    if (bus.clr) begin
      state_d     = StEmpty;
      buf_d       = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_count_d = '0;
    end else if (state_q == StHold) begin
      // Digits and backspace are swallowed here; only the handshake moves us on.
      if (out_valid_q && bus.out_ready) begin
        state_d     = StEmpty;
        out_valid_d = 1'b0;
        buf_d       = '0;
        count_d     = '0;
      end
    end else if (bus.enter) begin
      if (active) begin
        state_d     = StHold;
        out_valid_d = 1'b1;
        out_data_d  = buf_q;
        out_count_d = count_q;
      end
`ifdef KEYPAD_BACKSPACE_EN
    end else if (bus.bksp) begin
      if (active) begin
        buf_d   = trimmed;
        count_d = count_q - CW'(1);
        state_d = (count_q == CW'(1)) ? StEmpty : StEntry;
      end
`endif
    end else if (bus.in_valid) begin
      if (state_q == StFull) begin
        overflow_d = 1'b1;
        if (OVERFLOW_MODE == OVF_SHIFT) begin
          buf_d = shifted;
        end
      end else begin
        buf_d   = shifted;
        count_d = count_q + CW'(1);
        state_d = (count_q + CW'(1) == COUNT_MAX) ? StFull : StEntry;
      end
    end
  end

  always_ff @(posedge trig or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      buf_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.out       = buf_q;
  assign bus.count     = count_q;
  assign bus.empty     = (count_q == '0);
  assign bus.full      = (count_q == COUNT_MAX);
  assign bus.overflow  = overflow_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_keypad_digit_buffer.sv
// Directed bench for keypad_digit_buffer: one DUT per overflow policy, driven in lockstep.
module tb_keypad_digit_buffer;

  logic trig  = 1'b0;
  logic reset = 1'b1;
  logic dir_v = 1'b0;
  logic rdy_v = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 trig = ~trig;

  keypad_digit_buffer_if #(.COUNT(4), .WIDTH(4)) bus0 ();
  keypad_digit_buffer_if #(.COUNT(4), .WIDTH(4)) bus1 ();

  keypad_digit_buffer #(.COUNT(4), .WIDTH(4), .OVERFLOW_MODE(0)) dut_drop (
    .trig  (trig),
    .reset (reset),
    .bus   (bus0.slave)
  );

  keypad_digit_buffer #(.COUNT(4), .WIDTH(4), .OVERFLOW_MODE(1)) dut_shift (
    .trig  (trig),
    .reset (reset),
    .bus   (bus1.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic iv, input logic [3:0] d, input logic c, input logic b,
                        input logic e);
    bus0.in_valid = iv; bus0.in = d; bus0.clr = c; bus0.bksp = b; bus0.enter = e;
    bus0.dir = dir_v; bus0.out_ready = rdy_v;
    bus1.in_valid = iv; bus1.in = d; bus1.clr = c; bus1.bksp = b; bus1.enter = e;
    bus1.dir = dir_v; bus1.out_ready = rdy_v;
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic iv, input logic [3:0] d, input logic c, input logic b,
                      input logic e);
    set_in(iv, d, c, b, e);
    @(posedge trig);
    #1;
    set_in(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic digit(input logic [3:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    set_in(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge trig);
    #1;
    chk("reset_out", bus0.out, 16'h0000);
    chk("reset_count", bus0.count, 3'd0);
    chk("reset_empty", bus0.empty, 1'b1);
    chk("reset_full", bus0.full, 1'b0);
    chk("reset_valid", bus0.out_valid, 1'b0);
    chk("reset_ovf", bus0.overflow, 1'b0);
    reset = 1'b0;

    // Left entry up to full.
    digit(4'h1);
    chk("l1_out", bus0.out, 16'h0001);
    chk("l1_count", bus0.count, 3'd1);
    chk("l1_empty", bus0.empty, 1'b0);
    digit(4'h2);
    digit(4'h3);
    chk("l3_full", bus0.full, 1'b0);
    digit(4'h4);
    chk("l4_out", bus0.out, 16'h1234);
    chk("l4_count", bus0.count, 3'd4);
    chk("l4_full", bus0.full, 1'b1);

    // Digit while full: drop vs shift policy.
    digit(4'h5);
    chk("ovf_drop_out", bus0.out, 16'h1234);
    chk("ovf_drop_pulse", bus0.overflow, 1'b1);
    chk("ovf_shift_out", bus1.out, 16'h2345);
    chk("ovf_shift_count", bus1.count, 3'd4);
    chk("ovf_shift_pulse", bus1.overflow, 1'b1);
    idle();
    chk("ovf_pulse_end", bus0.overflow, 1'b0);

    // Commit and hold with consumer stalled.
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("enter_valid", bus0.out_valid, 1'b1);
    chk("enter_data", bus0.out_data, 16'h1234);
    chk("enter_count", bus0.out_count, 3'd4);
    chk("enter_data_m1", bus1.out_data, 16'h2345);
    digit(4'h7);
    chk("hold_no_ovf", bus0.overflow, 1'b0);
    digit(4'h8);
    idle();
    idle();
    idle();
    chk("hold_data", bus0.out_data, 16'h1234);
    chk("hold_out", bus0.out, 16'h1234);
    chk("hold_valid", bus0.out_valid, 1'b1);

    // Handshake; the digit in the same cycle is dropped.
    rdy_v = 1'b1;
    digit(4'h9);
    rdy_v = 1'b0;
    chk("hs_valid", bus0.out_valid, 1'b0);
    chk("hs_count", bus0.count, 3'd0);
    chk("hs_out", bus0.out, 16'h0000);
    chk("hs_data_kept", bus0.out_data, 16'h1234);
    digit(4'h6);
    chk("post_hs_out", bus0.out, 16'h0006);
    chk("post_hs_count", bus0.count, 3'd1);

    // clr beats enter and digit.
    step(1'b1, 4'h3, 1'b1, 1'b0, 1'b1);
    chk("clr_out", bus0.out, 16'h0000);
    chk("clr_empty", bus0.empty, 1'b1);
    chk("clr_valid", bus0.out_valid, 1'b0);
    chk("clr_data", bus0.out_data, 16'h0000);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("enter_empty", bus0.out_valid, 1'b0);

    // Right entry and backspace.
    dir_v = 1'b1;
    digit(4'h1);
    digit(4'h2);
    chk("r2_out", bus0.out, 16'h2100);
    chk("r2_count", bus0.count, 3'd2);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
`ifdef KEYPAD_BACKSPACE_EN
    chk("bs1_out", bus0.out, 16'h1000);
    chk("bs1_count", bus0.count, 3'd1);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("bs2_out", bus0.out, 16'h0000);
    chk("bs2_empty", bus0.empty, 1'b1);
`else
    chk("bs_off_out", bus0.out, 16'h2100);
    chk("bs_off_count", bus0.count, 3'd2);
`endif
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Direction change affects only later shifts.
    dir_v = 1'b0;
    digit(4'h1);
    dir_v = 1'b1;
    digit(4'h2);
    chk("dirchg_out", bus0.out, 16'h2000);
    chk("dirchg_count", bus0.count, 3'd2);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Consumer always ready: one-cycle hold.
    dir_v = 1'b0;
    rdy_v = 1'b1;
    digit(4'h4);
    digit(4'h5);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("rdy_hi_valid", bus0.out_valid, 1'b1);
    chk("rdy_hi_data", bus0.out_data, 16'h0045);
    chk("rdy_hi_ocount", bus0.out_count, 3'd2);
    idle();
    chk("rdy_hi_done", bus0.out_valid, 1'b0);
    chk("rdy_hi_empty", bus0.empty, 1'b1);
    rdy_v = 1'b0;

    // Asynchronous reset mid-entry.
    digit(4'h1);
    digit(4'h2);
    digit(4'h3);
    chk("pre_rst_count", bus0.count, 3'd3);
    chk("pre_rst_out", bus0.out, 16'h0123);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_out", bus0.out, 16'h0000);
    chk("async_rst_count", bus0.count, 3'd0);
    chk("async_rst_empty", bus0.empty, 1'b1);
    #1 reset = 1'b0;
    idle();
    chk("after_rst_count", bus0.count, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
